// File: rtl/oth_pkg.sv
// Shared types and defaults for the one-to-hot frame transmitter.
package oth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_PAY,
        ST_GAP
    } oth_state_e;

    localparam int                   OTH_HDR_W = 4;
    localparam logic [OTH_HDR_W-1:0] OTH_HDR   = 4'b1101;
    localparam int                   OTH_LEN_W = 4;
    localparam int                   OTH_PAY_W = (2 ** OTH_LEN_W) - 1;

    function automatic int oth_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/oth_bit_counter.sv
// Loadable down-counter with a terminal (count == 1) flag; indexes the bits of each frame field.
module oth_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         last
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/oth_frame_tx.sv
// Serial frame transmitter: start pattern, length field, then N payload bits, MSB first.
// Define OTH_TX_GAP_EN to append HDR_W invalid zero bits after every frame.
module oth_frame_tx
    import oth_pkg::*;
#(
    parameter int               HDR_W = OTH_HDR_W,
    parameter logic [HDR_W-1:0] HDR   = OTH_HDR,
    parameter int               LEN_W = OTH_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic [(2**LEN_W)-2:0]   data,
    output logic                    ready,
    output logic                    ser_out,
    output logic                    ser_out_valid,
    output logic                    done,
    output logic [LEN_W-1:0]        cnt_out
);

    localparam int PAY_W = (2 ** LEN_W) - 1;
    localparam int SH_W  = oth_max(HDR_W, PAY_W);
    localparam int CNT_W = $clog2(SH_W + 1);

`ifdef OTH_TX_GAP_EN
    localparam oth_state_e AFTER_FRAME = ST_GAP;
`else
    localparam oth_state_e AFTER_FRAME = ST_IDLE;
`endif

    // Left-align a w-bit field so its MSB sits at the shift-out end.
    function automatic logic [SH_W-1:0] left_align(input logic [SH_W-1:0] v, input int unsigned w);
        return v << (SH_W - w);
    endfunction

    oth_state_e         state, state_d;
    logic               accept, frame_end;
    logic [LEN_W-1:0]   len_q;
    logic [PAY_W-1:0]   data_q;
    logic [SH_W-1:0]    sh, sh_d, word;
    logic               ser_d, valid_d, done_d;
    logic               cnt_load, cnt_last;
    logic [CNT_W-1:0]   cnt_load_val, cnt;

    assign accept = clk_en && start && (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state;
        frame_end = 1'b0;
        if (clk_en) begin
            case (state)
                ST_IDLE: if (start) state_d = ST_HDR;
                ST_HDR:  if (cnt_last) state_d = ST_LEN;
                ST_LEN: begin
                    if (cnt_last) begin
                        if (len_q != '0) state_d = ST_PAY;
                        else             frame_end = 1'b1;
                    end
                end
                ST_PAY:  if (cnt_last) frame_end = 1'b1;
`ifdef OTH_TX_GAP_EN
                ST_GAP:  if (cnt_last) state_d = ST_IDLE;
`endif
                default: state_d = ST_IDLE;
            endcase
            if (frame_end) state_d = AFTER_FRAME;
        end
    end

    // Entering a field reloads the counter and shift register; otherwise keep shifting.
    always_comb begin
        word         = sh;
        sh_d         = sh;
        ser_d        = ser_out;
        valid_d      = ser_out_valid;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        if (clk_en) begin
            if (state_d != state) begin
                cnt_load = 1'b1;
                case (state_d)
                    ST_HDR: begin
                        cnt_load_val = CNT_W'(HDR_W);
                        word         = left_align(SH_W'(HDR), HDR_W);
                    end
                    ST_LEN: begin
                        cnt_load_val = CNT_W'(LEN_W);
                        word         = left_align(SH_W'(len_q), LEN_W);
                    end
                    ST_PAY: begin
                        cnt_load_val = CNT_W'(len_q);
                        word         = left_align(SH_W'(data_q), 32'(len_q));
                    end
                    ST_GAP: begin
                        cnt_load_val = CNT_W'(HDR_W);
                        word         = '0;
                    end
                    default: word = '0;
                endcase
            end
            case (state_d)
                ST_HDR, ST_LEN, ST_PAY: begin
                    ser_d   = word[SH_W-1];
                    valid_d = 1'b1;
                end
                default: begin
                    ser_d   = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
            sh_d   = word << 1;
            done_d = frame_end;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q         <= '0;
            data_q        <= '0;
            sh            <= '0;
            ser_out       <= 1'b0;
            ser_out_valid <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (accept) begin
                len_q  <= len;
                data_q <= data;
            end
            sh            <= sh_d;
            ser_out       <= ser_d;
            ser_out_valid <= valid_d;
            done          <= done_d;
        end
    end

    oth_bit_counter #(.W(CNT_W)) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .dec      (clk_en),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .cnt      (cnt),
        .last     (cnt_last)
    );

    assign ready   = (state == ST_IDLE);
    assign cnt_out = (state == ST_PAY) ? cnt[LEN_W-1:0] : '0;

endmodule

// File: tb/tb_oth_frame_tx.sv
// Directed self-checking bench for oth_frame_tx (default parameters).
module tb_oth_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [3:0]  len;
    logic [14:0] data;
    logic        ready, ser_out, ser_out_valid, done;
    logic [3:0]  cnt_out;

    int n_checks = 0;
    int n_errors = 0;

    oth_frame_tx dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .start         (start),
        .len           (len),
        .data          (data),
        .ready         (ready),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .done          (done),
        .cnt_out       (cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one enabled edge; clk_en is high once every `per` clocks, output must hold meanwhile.
    task automatic en_edge(input string tag, input int per, input logic exp_ser);
        for (int i = 0; i < per - 1; i++) begin
            clk_en = 1'b0;
            @(negedge clk);
            check({tag, "_hold"}, ser_out, exp_ser);
            check({tag, "_hold_done"}, done, 1'b0);
        end
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = (per == 1);
    endtask

    // Send one frame and check every bit; nchk < nbits stops mid-frame without the final edge.
    task automatic frame(input string tag, input logic [3:0] n, input logic [14:0] d,
                         input int nbits, input logic [31:0] bits, input int per,
                         input int nchk, input int glitch, input bit hold);
        len   = n;
        data  = d;
        start = 1'b1;
        en_edge(tag, per, 1'b0);
        if (!hold) start = 1'b0;
        for (int b = 0; b < nchk; b++) begin
            logic eb;
            eb = bits[nbits-1-b];
            check({tag, "_ser"}, ser_out, eb);
            check({tag, "_valid"}, ser_out_valid, 1'b1);
            check({tag, "_ready"}, ready, 1'b0);
            check({tag, "_done"}, done, 1'b0);
            check({tag, "_cnt"}, cnt_out, (b >= 8) ? (nbits - b) : 0);
            if (nchk < nbits && b == nchk - 1) return;
            if (b == glitch) begin
                start = 1'b1;
                len   = 4'd9;
                data  = 15'h2AAA;
            end else if (!hold) begin
                start = 1'b0;
            end
            en_edge(tag, per, eb);
        end
        check({tag, "_end_done"}, done, 1'b1);
        check({tag, "_end_ser"}, ser_out, 1'b0);
        check({tag, "_end_valid"}, ser_out_valid, 1'b0);
        check({tag, "_end_cnt"}, cnt_out, 4'd0);
`ifdef OTH_TX_GAP_EN
        check({tag, "_end_ready"}, ready, 1'b0);
`else
        check({tag, "_end_ready"}, ready, 1'b1);
`endif
        if (per > 1) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, done, 1'b0);
        end
`ifdef OTH_TX_GAP_EN
        for (int g = 0; g < 3; g++) begin
            en_edge(tag, per, 1'b0);
            check({tag, "_gap_ser"}, ser_out, 1'b0);
            check({tag, "_gap_valid"}, ser_out_valid, 1'b0);
            check({tag, "_gap_ready"}, ready, 1'b0);
        end
        en_edge(tag, per, 1'b0);
        check({tag, "_gap_idle_ready"}, ready, 1'b1);
        check({tag, "_gap_idle_ser"}, ser_out, 1'b0);
`endif
    endtask

    initial begin
        rst    = 1'b0;
        clk_en = 1'b0;
        start  = 1'b0;
        len    = '0;
        data   = '0;
        #2;
        check("rst_ready", ready, 1'b1);
        check("rst_ser", ser_out, 1'b0);
        check("rst_valid", ser_out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cnt", cnt_out, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // len=3, data=101: 1101 0011 101
        frame("len3", 4'd3, 15'b101, 11, 32'h69D, 1, 11, -1, 1'b0);
        // len=0: 1101 0000, no payload
        frame("len0", 4'd0, 15'h5A5A, 8, 32'hD0, 1, 8, -1, 1'b0);
        // len=15, all ones, clk_en 1 in 4: 1101 1111 + 15 ones
        frame("len15", 4'd15, 15'h7FFF, 23, 32'h6FFFFF, 4, 23, -1, 1'b0);
        // start with new len/data during LEN is ignored: 1101 0101 10110
        frame("glitch", 4'd5, 15'b10110, 13, 32'h1AB6, 1, 13, 5, 1'b0);

        // reset in PAY (second payload bit, cnt_out=3): 1101 0100 1111
        frame("rstpay", 4'd4, 15'hF, 12, 32'hD4F, 1, 10, -1, 1'b0);
        rst = 1'b0;
        #1;
        check("rstpay_async_ser", ser_out, 1'b0);
        check("rstpay_async_valid", ser_out_valid, 1'b0);
        check("rstpay_async_cnt", cnt_out, 4'd0);
        check("rstpay_async_ready", ready, 1'b1);
        @(negedge clk);
        check("rstpay_no_done", done, 1'b0);
        check("rstpay_ser_low", ser_out, 1'b0);
        rst = 1'b1;
        // full frame after reset: 1101 0001 1
        frame("after_rst", 4'd1, 15'h1, 9, 32'h1A3, 1, 9, -1, 1'b0);

        // back-to-back with start held: 1101 0010 10 twice
        frame("b2b_a", 4'd2, 15'b10, 10, 32'h34A, 1, 10, -1, 1'b1);
        frame("b2b_b", 4'd2, 15'b10, 10, 32'h34A, 1, 10, -1, 1'b0);

        clk_en = 1'b1;
        @(negedge clk);
        check("final_idle_ready", ready, 1'b1);
        check("final_idle_valid", ser_out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
